// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch (IF) and data (DM).
// Optional perf counters (perf_conflict, perf_wait) are compiled in when ARB_PERF_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_valid,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_F_mem,
    output logic                stall_M_mem,
`ifdef ARB_PERF_EN
    output logic [31:0]         perf_conflict,
    output logic [31:0]         perf_wait,
`endif
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_IF_WAIT = 2'd1;
    localparam logic [1:0] S_DM_WAIT = 2'd2;

    localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0] state;
    logic [3:0] lat_cnt;
    logic [3:0] starve_cnt;

    logic arb_en;
    logic grant_dm;
    logic grant_if;
    logic lat_done;

    // While a _valid pulse is out the requester still holds its old request,
    // so arbitrating in that cycle would serve the same access twice.
    always_comb begin
        arb_en   = (state == S_IDLE) && !if_valid && !dm_valid;
        grant_dm = arb_en && dm_req && ((starve_cnt < STARVE_LIM) || !if_req);
        grant_if = arb_en && if_req && !grant_dm;
        lat_done = (lat_cnt == LAT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            lat_cnt <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_dm) begin
                        state   <= S_DM_WAIT;
                        lat_cnt <= 4'd1;
                    end else if (grant_if) begin
                        state   <= S_IF_WAIT;
                        lat_cnt <= 4'd1;
                    end
                end
                S_IF_WAIT, S_DM_WAIT: begin
                    if (lat_done) begin
                        state   <= S_IDLE;
                        lat_cnt <= 4'd0;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    lat_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Memory command: fields are registered on the grant edge, mem_en is a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            mem_en <= grant_dm || grant_if;
            if (grant_dm) begin
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                mem_be    <= dm_be;
            end else if (grant_if) begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_be    <= {BE_W{1'b1}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata <= '0;
            if_valid <= 1'b0;
            dm_rdata <= '0;
            dm_valid <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            if (state == S_IF_WAIT && lat_done) begin
                if_rdata <= mem_rdata;
                if_valid <= 1'b1;
            end
            // Stores capture too; the word is meaningless but harmless.
            if (state == S_DM_WAIT && lat_done) begin
                dm_rdata <= mem_rdata;
                dm_valid <= 1'b1;
            end
        end
    end

    // Counts DM wins while fetch is waiting; at the limit fetch takes the next slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (!if_req || grant_if) begin
            starve_cnt <= 4'd0;
        end else if (grant_dm && (starve_cnt < STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign stall_F_mem = if_req && !if_valid;
    assign stall_M_mem = dm_req && !dm_valid;
    assign busy        = (state != S_IDLE);

`ifdef ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflict <= 32'd0;
            perf_wait     <= 32'd0;
        end else begin
            if (state == S_IDLE && if_req && dm_req)
                perf_conflict <= perf_conflict + 32'd1;
            if (stall_F_mem || stall_M_mem)
                perf_wait <= perf_wait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter against a transaction-level model of the arbitration rules.
// Fetch addresses live in 0x100-0x1FC, data addresses in 0x000-0x0FC, so bit 8 names the port.
module tb_mem_port_arbiter;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_valid, dm_valid, mem_en, mem_we, stall_F_mem, stall_M_mem, busy;
    logic [3:0]  mem_be;
`ifdef ARB_PERF_EN
    logic [31:0] perf_conflict, perf_wait;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata),
        .stall_F_mem(stall_F_mem), .stall_M_mem(stall_M_mem),
`ifdef ARB_PERF_EN
        .perf_conflict(perf_conflict), .perf_wait(perf_wait),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 64) ? 32'hDEADBEEF : 32'h1000_0000 + i * 32'h0001_0203;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Memory model: read data registered on the mem_en edge, sampled MEM_LAT(=2) edges after mem_en rose.
    logic [31:0] mem_arr [128];
    bit          mem_wr  [128];
    logic [31:0] rd_q;
    assign mem_rdata = rd_q;

    function automatic logic [31:0] word_at(input logic [6:0] i);
        return mem_wr[i] ? mem_arr[i] : init_word(int'(i));
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_arr[mem_addr[8:2]] <= merge(word_at(mem_addr[8:2]), mem_wdata, mem_be);
                mem_wr[mem_addr[8:2]]  <= 1'b1;
            end else begin
                rd_q <= word_at(mem_addr[8:2]);
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference state, owned by the monitor
    logic [31:0] ref_arr [128];
    bit          ref_wr  [128];
    bit          mon_on = 1'b0;
    bit          have_out, out_dm, out_st, if_prev, dm_prev;
    logic [31:0] out_exp;
    int          last_en = -1;
    int          starve_m = 0;
    int          cyc = 0;

    function automatic logic [31:0] ref_at(input logic [6:0] i);
        return ref_wr[i] ? ref_arr[i] : init_word(int'(i));
    endfunction

    task automatic monitor();
        if (!mon_on) begin
            have_out = 0; last_en = -1; starve_m = 0; if_prev = 0; dm_prev = 0;
            return;
        end
        chk("stall_F", stall_F_mem, if_req & ~if_valid);
        chk("stall_M", stall_M_mem, dm_req & ~dm_valid);
        if (mem_en) begin
            if (last_en >= 0) chk("en_gap_min", (cyc - last_en) >= MEM_LAT + 2, 1);
            chk("en_overlap", have_out, 0);
            out_dm = !mem_addr[8];
            if (out_dm) begin
                chk("dm_was_pending", dm_prev, 1);
                chk("dm_prio_ok", (starve_m < STARVE_MAX) || !if_prev, 1);
                chk("dm_addr", mem_addr, dm_addr);
                chk("dm_we", mem_we, dm_we);
                out_st = dm_we;
                if (dm_we) begin
                    chk("dm_wdata", mem_wdata, dm_wdata);
                    chk("dm_be", mem_be, dm_be);
                    ref_arr[dm_addr[8:2]] = merge(ref_at(dm_addr[8:2]), dm_wdata, dm_be);
                    ref_wr[dm_addr[8:2]]  = 1'b1;
                    out_exp = '0;
                end else begin
                    out_exp = ref_at(dm_addr[8:2]);
                end
            end else begin
                chk("if_was_pending", if_prev, 1);
                chk("if_prio_ok", !dm_prev || (starve_m >= STARVE_MAX), 1);
                chk("if_addr", mem_addr, if_addr);
                chk("if_we", mem_we, 0);
                chk("if_be", mem_be, 4'hF);
                out_st  = 1'b0;
                out_exp = ref_at(if_addr[8:2]);
            end
            have_out = 1;
            last_en  = cyc;
        end
        // fetch-waiting count as seen from grant decisions made last cycle
        if (!if_prev) starve_m = 0;
        else if (mem_en) starve_m = out_dm ? starve_m + 1 : 0;
        chk("busy", busy, have_out && ((cyc - last_en) < MEM_LAT));
        if (have_out && (cyc - last_en) == MEM_LAT) chk("valid_due", if_valid | dm_valid, 1);
        if (if_valid || dm_valid) begin
            chk("valid_has_access", have_out, 1);
            chk("valid_single", if_valid & dm_valid, 0);
            if (have_out) begin
                chk("valid_latency", cyc - last_en, MEM_LAT);
                chk("valid_port", dm_valid, out_dm);
                if (if_valid) chk("if_rdata", if_rdata, out_exp);
                if (dm_valid && !out_st) chk("dm_rdata", dm_rdata, out_exp);
            end
            have_out = 0;
        end
        if_prev = if_req;
        dm_prev = dm_req;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_en(input string tag);
        int n = 0;
        while (!mem_en && n < 50) begin tick(); n++; end
        chk(tag, mem_en, 1);
    endtask

    task automatic wait_dmv(input string tag);
        int n = 0;
        while (!dm_valid && n < 50) begin tick(); n++; end
        chk(tag, dm_valid, 1);
    endtask

    task automatic wait_ifv(input string tag);
        int n = 0;
        while (!if_valid && n < 50) begin tick(); n++; end
        chk(tag, if_valid, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((if_req || dm_req) && n < 100) begin
            tick(); n++;
            if (if_valid) if_req = 1'b0;
            if (dm_valid) dm_req = 1'b0;
        end
        chk("drain", {if_req, dm_req}, 0);
        tick(); tick();
    endtask

    initial begin
        logic [31:0] old;
        int t0, g, n, if_w, dm_w;
        bit stop;

        // reset with both requests up
        rst = 1; if_req = 1; dm_req = 1; if_addr = 32'h104; dm_addr = 32'h10;
        dm_we = 0; dm_wdata = 0; dm_be = 4'hF;
        #1;
        repeat (3) tick();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_misc", {mem_we, mem_wdata, mem_be}, 0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 0);
        chk("rst_valid_busy", {if_valid, dm_valid, busy}, 0);
        rst = 0; mon_on = 1;
        wait_en("first_grant_wait");
        chk("first_grant_dm", mem_addr[8], 0);
        wait_dmv("first_dm_done"); dm_req = 0;
        wait_ifv("first_if_done"); if_req = 0;
        tick(); tick();

        // single fetch
        if_req = 1; if_addr = 32'h100;
        #1;
        chk("t2_stall_c0", stall_F_mem, 1);
        tick();
        chk("t2_en_c1", {mem_en, mem_we}, 2'b10);
        chk("t2_addr_c1", mem_addr, 32'h100);
        chk("t2_be_c1", mem_be, 4'hF);
        chk("t2_stall_c1", stall_F_mem, 1);
        tick();
        chk("t2_c2", {mem_en, if_valid, stall_F_mem}, 3'b001);
        tick();
        chk("t2_valid_c3", {if_valid, stall_F_mem}, 2'b10);
        chk("t2_rdata_c3", if_rdata, 32'hDEADBEEF);
        if_req = 0;
        tick();
        chk("t2_hold", {if_valid, if_rdata}, {1'b0, 32'hDEADBEEF});
        tick();

        // store then read back
        old = word_at(7'd8);
        dm_req = 1; dm_we = 1; dm_addr = 32'h20; dm_wdata = 32'h12345678; dm_be = 4'b0011;
        tick();
        chk("t3_en", {mem_en, mem_we}, 2'b11);
        chk("t3_fields", {mem_addr, mem_wdata}, {32'h20, 32'h12345678});
        chk("t3_be", mem_be, 4'b0011);
        tick(); tick();
        chk("t3_ack", dm_valid, 1);
        dm_req = 0; dm_we = 0;
        chk("t3_mem", word_at(7'd8), {old[31:16], 16'h5678});
        tick();
        dm_req = 1; dm_be = 4'hF;
        wait_dmv("t3_load_wait");
        chk("t3_load", dm_rdata, {old[31:16], 16'h5678});
        dm_req = 0;
        tick(); tick();

        // contention: DM,DM,DM,DM,IF repeating
        if_req = 1; if_addr = 32'h104; dm_req = 1; dm_addr = 32'h40;
        g = 0; n = 0;
        while (g < 10 && n < 200) begin
            tick(); n++;
            if (mem_en) begin
                chk($sformatf("t4_grant%0d_is_if", g), mem_addr[8], (g % 5) == 4);
                g++;
            end
            if (if_valid) if_addr = 32'h100 | ($urandom_range(0, 63) << 2);
            if (dm_valid) dm_addr = $urandom_range(0, 63) << 2;
        end
        chk("t4_grants", g, 10);
        drain();

        // back-to-back loads
        dm_req = 1; dm_we = 0; dm_addr = 32'h0;
        wait_en("t5_en0");
        t0 = cyc;
        wait_dmv("t5_v0");
        dm_addr = 32'h4;
        wait_en("t5_en1");
        chk("t5_gap", cyc - t0, MEM_LAT + 2);
        wait_dmv("t5_v1");
        dm_req = 0;
        tick(); tick();

        // reset in the middle of an access
        dm_req = 1; dm_we = 0; dm_addr = 32'h8;
        wait_en("t6_en");
        tick();
        rst = 1; mon_on = 0;
        tick();
        chk("t6_no_valid", dm_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_mem_en", mem_en, 0);
        rst = 0; mon_on = 1; dm_addr = 32'hC;
        wait_dmv("t6_after_rst");
        chk("t6_rdata", dm_rdata, ref_at(7'd3));
        dm_req = 0;
        tick(); tick();

        // random traffic
        if_w = 0; dm_w = 0; stop = 0;
        for (int i = 0; i < 2500 && !stop; i++) begin
            tick();
            if (if_req) begin
                if_w++;
                if (if_valid) begin
                    chk("rnd_if_wait", if_w <= (STARVE_MAX + 2) * (MEM_LAT + 2), 1);
                    if_req  = ($urandom_range(0, 3) != 0);
                    if_addr = 32'h100 | ($urandom_range(0, 63) << 2);
                    if_w    = 0;
                end else if (if_w > 300) begin
                    chk("rnd_if_timeout", if_valid, 1);
                    stop = 1;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = 32'h100 | ($urandom_range(0, 63) << 2); if_w = 0;
            end
            if (dm_req) begin
                dm_w++;
                if (dm_valid) begin
                    chk("rnd_dm_wait", dm_w <= 3 * (MEM_LAT + 2), 1);
                    dm_req   = ($urandom_range(0, 3) != 0);
                    dm_we    = $urandom_range(0, 1);
                    dm_addr  = $urandom_range(0, 63) << 2;
                    dm_wdata = $urandom;
                    dm_be    = $urandom_range(1, 15);
                    dm_w     = 0;
                end else if (dm_w > 300) begin
                    chk("rnd_dm_timeout", dm_valid, 1);
                    stop = 1;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                dm_req = 1; dm_we = $urandom_range(0, 1); dm_addr = $urandom_range(0, 63) << 2;
                dm_wdata = $urandom; dm_be = $urandom_range(1, 15); dm_w = 0;
            end
        end
        if (!stop) drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
